// File: rtl/aes_key_schedule_if.sv
// rtl/aes_key_schedule_if.sv - control and round-key bus between a cipher core and the AES-128 key schedule
// The master drives start/key/direction/next; the slave presents one round key at a time.
interface aes_key_schedule_if;
  logic           i_start;
  logic [0:127]   i_key;
  logic           i_decrypt;
  logic           i_next;
  logic           o_busy;
  logic           o_valid;
  logic           o_last;
  logic [3:0]     o_round;
  logic [0:31]    o_key0;
  logic [0:31]    o_key1;
  logic [0:31]    o_key2;
  logic [0:31]    o_key3;

  modport master (
    output i_start, i_key, i_decrypt, i_next,
    input  o_busy, o_valid, o_last, o_round, o_key0, o_key1, o_key2, o_key3
  );

  modport slave (
    input  i_start, i_key, i_decrypt, i_next,
    output o_busy, o_valid, o_last, o_round, o_key0, o_key1, o_key2, o_key3
  );
endinterface

// File: rtl/aes_key_schedule.sv
// rtl/aes_key_schedule.sv - AES-128 key expansion into an 11-entry round-key store
// Expands one round key per cycle, then serves keys forward or reverse under a valid/next handshake.
module aes_key_schedule #(
  parameter int NR = 10
) (
  input  logic                i_clock,
  input  logic                i_reset,
  aes_key_schedule_if.slave   ks
);

  if (NR != 10) begin : g_bad_nr
    $error("aes_key_schedule: only NR=10 (AES-128) is supported");
  end

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_EXPAND = 2'd1,
    S_SERVE  = 2'd2
  } state_t;

  localparam logic [3:0] LAST_ROUND = 4'd10;

  // Forward S-box, byte b at bits [8b : 8b+7].
  localparam logic [0:2047] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sub_byte(input logic [7:0] b);
    return SBOX[{b, 3'b000} +: 8];
  endfunction

  state_t        state_q;
  logic          dir_q;
  logic [3:0]    cnt_q;
  logic [7:0]    rcon_q;
  logic [0:127]  work_q;
  logic [3:0]    round_q;
  logic          busy_q;
  logic          valid_q;
  logic          last_q;
  logic [0:127]  key_q;
  logic [0:127]  store_q [0:10];

  logic [0:31]   w0, w1, w2, w3, rot_w, sub_w, t_w;
  logic [0:31]   n0, n1, n2, n3;
  logic [0:127]  expand_d;
  logic [7:0]    rcon_d;
  logic [3:0]    round_d;
  logic [3:0]    end_round;

  assign w0       = work_q[0:31];
  assign w1       = work_q[32:63];
  assign w2       = work_q[64:95];
  assign w3       = work_q[96:127];
  assign rot_w    = {w3[8:31], w3[0:7]};
  assign sub_w    = {sub_byte(rot_w[0:7]),   sub_byte(rot_w[8:15]),
                     sub_byte(rot_w[16:23]), sub_byte(rot_w[24:31])};
  assign t_w      = sub_w ^ {rcon_q, 24'h000000};
  assign n0       = w0 ^ t_w;
  assign n1       = w1 ^ n0;
  assign n2       = w2 ^ n1;
  assign n3       = w3 ^ n2;
  assign expand_d = {n0, n1, n2, n3};
  assign rcon_d   = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);

  assign round_d   = dir_q ? (round_q - 4'd1) : (round_q + 4'd1);
  assign end_round = dir_q ? 4'd0 : LAST_ROUND;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      dir_q   <= 1'b0;
      cnt_q   <= 4'd0;
      rcon_q  <= 8'h00;
      work_q  <= '0;
      round_q <= 4'd0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      key_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (ks.i_start) begin
            work_q  <= ks.i_key;
            dir_q   <= ks.i_decrypt;
            cnt_q   <= 4'd1;
            rcon_q  <= 8'h01;
            busy_q  <= 1'b1;
            state_q <= S_EXPAND;
          end
        end
        S_EXPAND: begin
          work_q <= expand_d;
          rcon_q <= rcon_d;
          if (cnt_q == LAST_ROUND) begin
            // store[10] lands on this same edge, so a reverse run takes it straight from the datapath
            state_q <= S_SERVE;
            valid_q <= 1'b1;
            last_q  <= 1'b0;
            cnt_q   <= 4'd0;
            round_q <= dir_q ? LAST_ROUND : 4'd0;
            key_q   <= dir_q ? expand_d : store_q[0];
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        S_SERVE: begin
          if (ks.i_next) begin
            if (last_q) begin
              state_q <= S_IDLE;
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              busy_q  <= 1'b0;
              round_q <= 4'd0;
              key_q   <= '0;
            end else begin
              round_q <= round_d;
              key_q   <= store_q[round_d];
              last_q  <= (round_d == end_round);
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clock) begin
    if (state_q == S_IDLE && ks.i_start) begin
      store_q[0] <= ks.i_key;
    end else if (state_q == S_EXPAND) begin
      store_q[cnt_q] <= expand_d;
    end
  end

  assign ks.o_busy  = busy_q;
  assign ks.o_valid = valid_q;
  assign ks.o_last  = last_q;
  assign ks.o_round = round_q;
  assign ks.o_key0  = key_q[0:31];
  assign ks.o_key1  = key_q[32:63];
  assign ks.o_key2  = key_q[64:95];
  assign ks.o_key3  = key_q[96:127];

endmodule

// File: tb/tb_aes_key_schedule.sv
// tb/tb_aes_key_schedule.sv - directed FIPS-197 checks of aes_key_schedule
// Inputs driven 1ns after the rising edge; outputs sampled at that point, well away from the next edge.
module tb_aes_key_schedule;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  int   lat;

  aes_key_schedule_if ks ();

  aes_key_schedule #(.NR(10)) dut (
    .i_clock (clk),
    .i_reset (rst),
    .ks      (ks)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [127:0] ka [0:10] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c,
    128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f,
    128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00,
    128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd,
    128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f,
    128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };
  logic [127:0] kc0  = 128'h000102030405060708090a0b0c0d0e0f;
  logic [127:0] kc10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [127:0] cur_key();
    return {ks.o_key0, ks.o_key1, ks.o_key2, ks.o_key3};
  endfunction

  function automatic logic [127:0] flags();
    return {121'd0, ks.o_busy, ks.o_valid, ks.o_last, ks.o_round};
  endfunction

  task automatic start_ks(input logic [127:0] key, input logic dec);
    ks.i_key     = key;
    ks.i_decrypt = dec;
    ks.i_start   = 1'b1;
    tick();
    ks.i_start   = 1'b0;
  endtask

  task automatic wait_valid(input int already, output int l);
    l = already;
    while (ks.o_valid !== 1'b1 && l < 40) begin
      tick();
      l++;
    end
  endtask

  task automatic step();
    ks.i_next = 1'b1;
    tick();
    ks.i_next = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_flags"}, flags(), 128'd0);
    chk({tag, "_key"}, cur_key(), 128'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    ks.i_start = 1'b0; ks.i_key = '0; ks.i_decrypt = 1'b0; ks.i_next = 1'b0;
    rst = 1'b1;
    #2;
    chk_zero("reset");
    #20 rst = 1'b0;
    tick();

    // 1/2: forward sequence, exact latency, every round key and last flag
    start_ks(ka[0], 1'b0);
    chk("busy_expand", {127'd0, ks.o_busy}, 128'd1);
    chk("valid_expand", {127'd0, ks.o_valid}, 128'd0);
    wait_valid(0, lat);
    chk("latency_fwd", lat, 10);
    for (int r = 0; r <= 10; r++) begin
      chk($sformatf("fwd_round%0d", r), ks.o_round, r);
      chk($sformatf("fwd_key%0d", r), cur_key(), ka[r]);
      chk($sformatf("fwd_last%0d", r), ks.o_last, (r == 10));
      step();
    end
    chk("fwd_done", flags(), 128'd0);

    // 3: reverse sequence
    start_ks(ka[0], 1'b1);
    wait_valid(0, lat);
    chk("latency_rev", lat, 10);
    for (int r = 10; r >= 0; r--) begin
      chk($sformatf("rev_round%0d", r), ks.o_round, r);
      chk($sformatf("rev_key%0d", r), cur_key(), ka[r]);
      chk($sformatf("rev_last%0d", r), ks.o_last, (r == 0));
      step();
    end
    chk("rev_done", flags(), 128'd0);

    // 4: stall, and start pulses that must be ignored
    start_ks(ka[0], 1'b0);
    ks.i_key = kc0; ks.i_decrypt = 1'b1; ks.i_start = 1'b1;
    tick();
    ks.i_start = 1'b0;
    wait_valid(1, lat);
    chk("latency_restart_ignored", lat, 10);
    chk("restart_round", ks.o_round, 0);
    chk("restart_key", cur_key(), ka[0]);
    repeat (20) tick();
    chk("hold_round", ks.o_round, 0);
    chk("hold_key", cur_key(), ka[0]);
    step(); step(); step();
    chk("step3_key", cur_key(), ka[3]);
    ks.i_start = 1'b1;
    tick();
    chk("serve_start_round", ks.o_round, 3);
    chk("serve_start_key", cur_key(), ka[3]);
    ks.i_next = 1'b1;
    tick();
    ks.i_next = 1'b0; ks.i_start = 1'b0;
    chk("start_next_round", ks.o_round, 4);
    chk("start_next_key", cur_key(), ka[4]);
    for (int r = 5; r <= 10; r++) begin
      step();
      chk($sformatf("cont_key%0d", r), cur_key(), ka[r]);
    end
    chk("cont_last", ks.o_last, 1);
    ks.i_next = 1'b1; ks.i_start = 1'b1;
    tick();
    ks.i_next = 1'b0; ks.i_start = 1'b0;
    chk("exit_flags", flags(), 128'd0);
    tick();
    chk("exit_start_ignored", flags(), 128'd0);
    step();
    chk("idle_next_ignored", flags(), 128'd0);

    // 5a: async reset mid-EXPAND
    start_ks(ka[0], 1'b0);
    repeat (4) tick();
    #3 rst = 1'b1;
    #1 chk_zero("rst_expand");
    #1 rst = 1'b0;
    tick();
    start_ks(ka[0], 1'b0);
    wait_valid(0, lat);
    chk("latency_after_rst", lat, 10);
    chk("rst_expand_key0", cur_key(), ka[0]);
    step();
    chk("rst_expand_key1", cur_key(), ka[1]);

    // 5b: async reset mid-SERVE at round 4
    step(); step(); step();
    chk("pre_rst_round", ks.o_round, 4);
    chk("pre_rst_key", cur_key(), ka[4]);
    #3 rst = 1'b1;
    #1 chk_zero("rst_serve");
    #1 rst = 1'b0;
    tick();
    chk_zero("rst_serve_idle");
    start_ks(ka[0], 1'b0);
    wait_valid(0, lat);
    chk("latency_after_rst2", lat, 10);
    step();
    chk("rst_serve_key1", cur_key(), ka[1]);
    repeat (10) step();
    chk("rst_serve_done", flags(), 128'd0);

    // 6: FIPS-197 C.1 key, reverse so round 10 comes first
    start_ks(kc0, 1'b1);
    wait_valid(0, lat);
    chk("c1_latency", lat, 10);
    chk("c1_round", ks.o_round, 10);
    chk("c1_key10", cur_key(), kc10);
    repeat (10) step();
    chk("c1_key0", cur_key(), kc0);
    chk("c1_last", ks.o_last, 1);
    step();
    chk("c1_done", flags(), 128'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
